// File: rtl/servo_frame_scheduler.sv
// ============================================================================
// servo_frame_scheduler
//
// Shares one pulse-width timebase among up to four servo outputs. Framed
// serial commands (start bit, 2-bit channel, 8-bit position, stop bit) are
// received on mbed_pulse and stored in per-channel shadow registers. At every
// frame boundary the shadow registers are copied into the active registers in
// one step, and each active channel then gets one pulse in its own slot.
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   rst         asynchronous active-high reset
//   mbed_pulse  serial command line, idle low
//   servo_pwm   registered servo pulses, one bit per channel
//   frame_start one-clock pulse at the start of each frame
//   rx_busy     high while a command is being received
//   rx_valid    one-clock pulse when a command is accepted
//   rx_err      one-clock pulse when a command is rejected
// ============================================================================
module servo_frame_scheduler #(
    parameter int TICK_DIV    = 50,
    parameter int SLOT_TICKS  = 2500,
    parameter int FRAME_SLOTS = 8,
    parameter int NUM_SERVOS  = 4,
    parameter int BASE_TICKS  = 1000,
    parameter int SCALE_SHIFT = 2,
    parameter int BIT_CLKS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mbed_pulse,
    output logic [NUM_SERVOS-1:0] servo_pwm,
    output logic                  frame_start,
    output logic                  rx_busy,
    output logic                  rx_valid,
    output logic                  rx_err
);

    localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int SLW = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
    localparam int BCW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [TDW-1:0] TICK_LAST      = TDW'(TICK_DIV - 1);
    localparam logic [STW-1:0] SLOT_TICK_LAST = STW'(SLOT_TICKS - 1);
    localparam logic [SLW-1:0] SLOT_LAST      = SLW'(FRAME_SLOTS - 1);
    localparam logic [BCW-1:0] BIT_LAST       = BCW'(BIT_CLKS - 1);
    localparam logic [31:0]    WIDTH_MAX      = 32'(SLOT_TICKS - 1);
    localparam logic [7:0]     POS_RESET      = 8'd128;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_STOP  = 2'd2
    } rxState_t;

    // Timebase
    logic [TDW-1:0]        r_tickDiv;
    logic [STW-1:0]        r_slotTick;
    logic [SLW-1:0]        r_slot;

    // Position storage and outputs
    logic [7:0]            r_shadow [NUM_SERVOS];
    logic [7:0]            r_active [NUM_SERVOS];
    logic [NUM_SERVOS-1:0] r_pwm;
    logic                  r_frameStart;

    // Receiver
    rxState_t              r_rxState;
    rxState_t              w_rxStateNext;
    logic [BCW-1:0]        r_clkCnt;
    logic [3:0]            r_bitCnt;
    logic [9:0]            r_shift;
    logic                  r_stopBit;
    logic                  r_complete;
    logic                  r_rxBusy;
    logic                  r_rxValid;
    logic                  r_rxErr;

    logic                  w_frameZero;
    logic                  w_slotOffsetZero;
    logic [31:0]           w_width [NUM_SERVOS];
    logic [31:0]           w_rawWidth;
    logic [NUM_SERVOS-1:0] w_pwmNext;
    logic                  w_bitStrobe;
    logic                  w_busyNext;
    logic [1:0]            w_cmdChannel;
    logic [7:0]            w_cmdPos;
    logic                  w_cmdOk;
    logic                  w_accept;
    logic                  w_reject;

    assign w_frameZero      = (r_tickDiv == '0) && (r_slotTick == '0) && (r_slot == '0);
    assign w_slotOffsetZero = (r_tickDiv == '0) && (r_slotTick == '0);
    assign w_bitStrobe      = (r_clkCnt == BIT_LAST);
    assign w_cmdChannel     = r_shift[9:8];
    assign w_cmdPos         = r_shift[7:0];

    // Tick divider, slot tick and slot index form one free-running counter
    // chain; the frame boundary is the point where all three are zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tickDiv  <= '0;
            r_slotTick <= '0;
            r_slot     <= '0;
        end else if (r_tickDiv == TICK_LAST) begin
            r_tickDiv <= '0;
            if (r_slotTick == SLOT_TICK_LAST) begin
                r_slotTick <= '0;
                r_slot     <= (r_slot == SLOT_LAST) ? '0 : r_slot + SLW'(1);
            end else begin
                r_slotTick <= r_slotTick + STW'(1);
            end
        end else begin
            r_tickDiv <= r_tickDiv + TICK_DIV'(0) + TDW'(1);
        end
    end

    // Pulse width per channel, clamped so a pulse always ends inside its slot.
    always_comb begin
        w_rawWidth = '0;
        for (int i = 0; i < NUM_SERVOS; i++) begin
            w_rawWidth = 32'(BASE_TICKS) + (32'(r_active[i]) << SCALE_SHIFT);
            w_width[i] = (w_rawWidth > WIDTH_MAX) ? WIDTH_MAX : w_rawWidth;
        end
    end

    // The pulse register is loaded one clock behind the counter position, so
    // the output is high for slot offsets 1..W*TICK_DIV. In (tick, divider)
    // terms that is "not at offset 0" and "before tick W, or exactly at tick W
    // with divider 0". This avoids any multiply by TICK_DIV.
    always_comb begin
        w_pwmNext = '0;
        for (int i = 0; i < NUM_SERVOS; i++) begin
            if ((r_slot == SLW'(i)) && !w_slotOffsetZero) begin
                if ((32'(r_slotTick) < w_width[i]) ||
                    ((32'(r_slotTick) == w_width[i]) && (r_tickDiv == '0))) begin
                    w_pwmNext[i] = 1'b1;
                end
            end
        end
    end

    // Active positions change only at the frame boundary. A write landing on
    // that same edge reaches the shadow too late and waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm        <= '0;
            r_frameStart <= 1'b0;
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_active[i] <= POS_RESET;
            end
        end else begin
            r_pwm        <= w_pwmNext;
            r_frameStart <= w_frameZero;
            if (w_frameZero) begin
                for (int i = 0; i < NUM_SERVOS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // Shadow registers take each accepted command; the last write wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                r_shadow[i] <= POS_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                if (w_accept && (w_cmdChannel == 2'(i))) begin
                    r_shadow[i] <= w_cmdPos;
                end
            end
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxState <= RX_IDLE;
        end else begin
            r_rxState <= w_rxStateNext;
        end
    end

    // Receiver next state. STOP returns to IDLE right after sampling the stop
    // bit, so the completion edge is an IDLE cycle and can already take the
    // start bit of a back-to-back command.
    always_comb begin
        w_rxStateNext = r_rxState;
        case (r_rxState)
            RX_IDLE:  if (mbed_pulse) w_rxStateNext = RX_SHIFT;
            RX_SHIFT: if (w_bitStrobe && (r_bitCnt == 4'd9)) w_rxStateNext = RX_STOP;
            RX_STOP:  if (w_bitStrobe) w_rxStateNext = RX_IDLE;
            default:  w_rxStateNext = RX_IDLE;
        endcase
    end

    // Receiver outputs. Busy is held through the stop-bit edge and drops on
    // the completion edge unless a new start bit arrives there.
    always_comb begin
        w_busyNext = (w_rxStateNext != RX_IDLE) || (r_rxState == RX_STOP);
        w_cmdOk    = !r_stopBit && (32'(w_cmdChannel) < 32'(NUM_SERVOS));
        w_accept   = r_complete && w_cmdOk;
        w_reject   = r_complete && !w_cmdOk;
    end

    // Receiver datapath: bit timing, shift register and the completion flag
    // that turns the sampled stop bit into a valid/error pulse one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkCnt   <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_stopBit  <= 1'b0;
            r_complete <= 1'b0;
            r_rxBusy   <= 1'b0;
            r_rxValid  <= 1'b0;
            r_rxErr    <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            r_rxBusy   <= w_busyNext;
            r_rxValid  <= w_accept;
            r_rxErr    <= w_reject;
            case (r_rxState)
                RX_SHIFT: begin
                    if (w_bitStrobe) begin
                        r_clkCnt <= '0;
                        r_shift  <= {r_shift[8:0], mbed_pulse};
                        r_bitCnt <= r_bitCnt + 4'd1;
                    end else begin
                        r_clkCnt <= r_clkCnt + BCW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_bitStrobe) begin
                        r_clkCnt   <= '0;
                        r_stopBit  <= mbed_pulse;
                        r_complete <= 1'b1;
                    end else begin
                        r_clkCnt <= r_clkCnt + BCW'(1);
                    end
                end
                default: begin
                    r_clkCnt <= '0;
                    r_bitCnt <= '0;
                end
            endcase
        end
    end

    assign servo_pwm   = r_pwm;
    assign frame_start = r_frameStart;
    assign rx_busy     = r_rxBusy;
    assign rx_valid    = r_rxValid;
    assign rx_err      = r_rxErr;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// ============================================================================
// tb_servo_frame_scheduler
//
// Drives serial commands into two copies of the scheduler (four and three
// channels) and keeps a timeline model of shadow/active positions. Expected
// pulses, receiver results and shadow writes are queued when stimulus is
// driven or a frame begins, and checked when the DUT produces them.
// ============================================================================
module tb_servo_frame_scheduler;

    localparam int TICK_DIV    = 2;
    localparam int SLOT_TICKS  = 40;
    localparam int FRAME_SLOTS = 6;
    localparam int BASE_TICKS  = 8;
    localparam int SLOT_CLKS   = SLOT_TICKS * TICK_DIV;
    localparam int FRAME_CLKS  = FRAME_SLOTS * SLOT_CLKS;

    typedef struct { int edgeN; int ch; int pos; } wrEntry_t;
    typedef struct { int edgeN; bit v4; bit v3; bit busyAfter; } rxEntry_t;
    typedef struct { int ch; int rise; int width; } pulseEntry_t;

    logic       clk;
    logic       rst;
    logic       mbed_pulse;
    logic [3:0] servo_pwm;
    logic       frame_start;
    logic       rx_busy;
    logic       rx_valid;
    logic       rx_err;
    logic [2:0] pwm3;
    logic       fs3;
    logic       busy3;
    logic       val3;
    logic       err3;

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc;

    wrEntry_t    pendW[$];
    rxEntry_t    expRx[$];
    pulseEntry_t expPulse[$];
    int          modelShadow [4];
    int          modelActive [4];
    int          riseEdge [4];
    logic [3:0]  prevPwm;

    servo_frame_scheduler #(
        .TICK_DIV(TICK_DIV), .SLOT_TICKS(SLOT_TICKS), .FRAME_SLOTS(FRAME_SLOTS),
        .NUM_SERVOS(4), .BASE_TICKS(BASE_TICKS), .SCALE_SHIFT(0), .BIT_CLKS(1)
    ) dut (
        .clk(clk), .rst(rst), .mbed_pulse(mbed_pulse), .servo_pwm(servo_pwm),
        .frame_start(frame_start), .rx_busy(rx_busy), .rx_valid(rx_valid), .rx_err(rx_err)
    );

    servo_frame_scheduler #(
        .TICK_DIV(TICK_DIV), .SLOT_TICKS(SLOT_TICKS), .FRAME_SLOTS(FRAME_SLOTS),
        .NUM_SERVOS(3), .BASE_TICKS(BASE_TICKS), .SCALE_SHIFT(0), .BIT_CLKS(1)
    ) dut3 (
        .clk(clk), .rst(rst), .mbed_pulse(mbed_pulse), .servo_pwm(pwm3),
        .frame_start(fs3), .rx_busy(busy3), .rx_valid(val3), .rx_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release: the first rising edge after release is 0.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= -1;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int expWidthClks(input int pos);
        int w;
        w = BASE_TICKS + pos;
        if (w > SLOT_TICKS - 1) w = SLOT_TICKS - 1;
        return w * TICK_DIV;
    endfunction

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic idleLine();
        @(negedge clk);
        mbed_pulse = 1'b0;
    endtask

    // Sends start, channel[1:0], position[7:0], stop, one bit per clock, and
    // queues what the receivers and the shadow registers should do with it.
    task automatic applyStimulus(input int ch, input int pos, input bit stopBit);
        logic [11:0] bits;
        int          s;
        rxEntry_t    e;
        wrEntry_t    w;
        bits = {1'b1, 2'(ch), 8'(pos), stopBit};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                s = cyc + 1;
                for (int q = 0; q < expRx.size(); q++) begin
                    if (expRx[q].edgeN == s) expRx[q].busyAfter = 1'b1;
                end
                e.edgeN     = s + 12;
                e.v4        = !stopBit && (ch < 4);
                e.v3        = !stopBit && (ch < 3);
                e.busyAfter = 1'b0;
                expRx.push_back(e);
                if (e.v4) begin
                    w.edgeN = s + 12;
                    w.ch    = ch;
                    w.pos   = pos;
                    pendW.push_back(w);
                end
            end
            if (k == 1) checkOutput("rxBusyStart", rx_busy, 1);
            mbed_pulse = bits[11-k];
        end
    endtask

    // Monitor and scoreboard, sampled on the falling edge.
    pulseEntry_t mPulse;
    rxEntry_t    mRx;
    int          n;
    bit          expFs;

    always @(negedge clk) begin
        if (rst || cyc < 0) begin
            prevPwm = '0;
        end else begin
            n     = cyc;
            expFs = ((n % FRAME_CLKS) == 0);
            if (frame_start || expFs) checkOutput("frameStart", frame_start, expFs);
            if (fs3 || expFs)         checkOutput("frameStart3", fs3, expFs);

            if (expFs) begin
                for (int c = 0; c < 4; c++) begin
                    modelActive[c] = modelShadow[c];
                    mPulse.ch      = c;
                    mPulse.rise    = n + 1 + c * SLOT_CLKS;
                    mPulse.width   = expWidthClks(modelActive[c]);
                    expPulse.push_back(mPulse);
                end
            end
            while (pendW.size() > 0 && pendW[0].edgeN == n) begin
                modelShadow[pendW[0].ch] = pendW[0].pos;
                void'(pendW.pop_front());
            end

            if (expRx.size() > 0 && expRx[0].edgeN == n) begin
                mRx = expRx.pop_front();
                checkOutput("rxValid",    rx_valid, mRx.v4);
                checkOutput("rxErr",      rx_err,   !mRx.v4);
                checkOutput("rxValid3",   val3,     mRx.v3);
                checkOutput("rxErr3",     err3,     !mRx.v3);
                checkOutput("rxBusyDone", rx_busy,  mRx.busyAfter);
            end else if (rx_valid || rx_err || val3 || err3) begin
                checkOutput("rxSpurious", {rx_valid, rx_err, val3, err3}, 0);
            end

            for (int i = 0; i < 4; i++) begin
                if (servo_pwm[i] && !prevPwm[i]) begin
                    riseEdge[i] = n;
                    checkOutput("pwmOneHot", $countones(servo_pwm), 1);
                end else if (!servo_pwm[i] && prevPwm[i]) begin
                    if (expPulse.size() == 0) begin
                        checkOutput("pulseUnexpected", i, -1);
                    end else begin
                        mPulse = expPulse.pop_front();
                        checkOutput("pulseCh",    i,               mPulse.ch);
                        checkOutput("pulseRise",  riseEdge[i],     mPulse.rise);
                        checkOutput("pulseWidth", n - riseEdge[i], mPulse.width);
                    end
                end
            end
            prevPwm = servo_pwm;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int c = 0; c < 4; c++) begin
            modelShadow[c] = 128;
            modelActive[c] = 128;
            riseEdge[c]    = 0;
        end
        prevPwm    = '0;
        mbed_pulse = 1'b0;
        rst        = 1'b1;
        #2;
        checkOutput("resetOut",  {servo_pwm, frame_start, rx_busy, rx_valid, rx_err}, 0);
        checkOutput("resetOut3", {pwm3, fs3, busy3, val3, err3}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] default frame plus single command on channel 2");
        waitCycle(18);
        applyStimulus(2, 20, 1'b0);

        $display("[TB] rejected commands: bad stop bit, channel 3 on the 3-servo copy");
        waitCycle(500);
        applyStimulus(0, 3, 1'b1);
        idleLine();
        waitCycle(540);
        applyStimulus(3, 7, 1'b0);

        $display("[TB] command completing on the frame boundary");
        waitCycle(946);
        applyStimulus(0, 25, 1'b0);

        $display("[TB] back-to-back writes to channel 1");
        waitCycle(1498);
        applyStimulus(1, 5, 1'b0);
        applyStimulus(1, 10, 1'b0);

        $display("[TB] reset during a pulse and a reception");
        waitCycle(2094);
        @(negedge clk); mbed_pulse = 1'b1;
        @(negedge clk); mbed_pulse = 1'b0;
        @(negedge clk); mbed_pulse = 1'b1;
        @(negedge clk); mbed_pulse = 1'b1;
        checkOutput("pwmBeforeReset",  servo_pwm, 4'b0100);
        checkOutput("busyBeforeReset", rx_busy,   1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncResetOut",  {servo_pwm, frame_start, rx_busy, rx_valid, rx_err}, 0);
        checkOutput("asyncResetOut3", {pwm3, fs3, busy3, val3, err3}, 0);
        expPulse.delete();
        expRx.delete();
        pendW.delete();
        for (int c = 0; c < 4; c++) modelShadow[c] = 128;
        mbed_pulse = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        waitCycle(330);
        checkOutput("pulseDrain", expPulse.size(), 0);
        checkOutput("rxDrain",    expRx.size(),    0);
        checkOutput("writeDrain", pendW.size(),    0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
